serial_frame_ctrl: RTL and testbench

//   Frame sequencer for the 4-bit serial-to-parallel shift register.
//   - Detects the start bit on the serial line, counts data bits and drives the SIPO shift/clear strobes.
//   - Checks the stop bit, then captures the SIPO word into a holding register.
//   - Hands the word out over a valid/ready handshake.

---
 rtl/serial_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_serial_frame_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// serial_frame_ctrl
//   Frame sequencer for an external WIDTH-bit serial-to-parallel shift register
//   (SIPO). It watches the serial line on each bit_tick and does the following:
//   - finds the start bit
//   - drives the SIPO clear/shift strobes through the data bits
//   - checks the stop bit (and the parity bit when enabled)
//   - captures the SIPO word into a holding register
//   The held word is handed out over a valid/ready handshake.
//
//   Optional feature: define SERIAL_FRAME_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit. Frames are then WIDTH+3 ticks long
//   instead of WIDTH+2.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   ena         design enable; low aborts any frame and holds IDLE
//   bit_tick    one-cycle sample strobe, one serial bit per tick
//   serial_in   serial line, idles high
//   sipo_clr    clears the SIPO this cycle (combinational)
//   sipo_shift  SIPO shifts serial_in this cycle (combinational)
//   sipo_q      SIPO parallel output
//   word_out    held received word
//   word_valid  word_out holds an unconsumed word
//   word_ready  consumer accepts word_out while word_valid=1
//   busy        high whenever the sequencer is not IDLE
//   frame_err   one-cycle pulse on a bad stop (or parity) bit
//   overrun     sticky flag: a completed frame was dropped
//   clr_err     synchronous clear of overrun
// -----------------------------------------------------------------------------
module serial_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             bit_tick,
  input  logic             serial_in,
  output logic             sipo_clr,
  output logic             sipo_shift,
  input  logic [WIDTH-1:0] sipo_q,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             tick_en;
  logic             stop_ok;
  logic             stop_tick;
  logic             capture;
  logic             drop;

  assign tick_en = ena & bit_tick;

`ifdef SERIAL_FRAME_PARITY_EN
  localparam logic [1:0] S_PARITY     = 2'd2;
  localparam logic [1:0] S_AFTER_DATA = S_PARITY;

  // The running XOR of the data bits is compared against the parity bit.
  // The result is held until the stop tick so that a parity failure and a
  // bad stop bit are reported the same way.
  logic par_acc;
  logic par_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else if (tick_en) begin
      case (state)
        S_IDLE:   begin
                    par_acc <= 1'b0;
                    par_err <= 1'b0;
                  end
        S_DATA:   par_acc <= par_acc ^ serial_in;
        S_PARITY: par_err <= par_acc ^ serial_in;
        default:  ;
      endcase
    end
  end

  assign stop_ok = serial_in & ~par_err;
`else
  localparam logic [1:0] S_AFTER_DATA = S_STOP;

  assign stop_ok = serial_in;
`endif

  // The strobes are combinational but must stay low while reset is held.
  // Otherwise an active start bit during reset would clear the SIPO.
  // NOTE: rst_n is used as a plain data term here. It is still asynchronous,
  // but it only gates outputs and feeds no register.
  assign sipo_clr   = rst_n & tick_en & (state == S_IDLE) & ~serial_in;
  assign sipo_shift = rst_n & tick_en & (state == S_DATA);
  assign busy       = (state != S_IDLE);

  assign stop_tick = tick_en & (state == S_STOP);
  assign capture   = stop_tick & stop_ok;
  // A completed frame is lost only if the previous word is still pending
  // and is not being taken in this same cycle.
  assign drop      = capture & word_valid & ~word_ready;

  // Sequencer. ena low aborts the frame immediately. Without a tick,
  // everything holds.
  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
    end else if (!ena) begin
      state <= S_IDLE;
    end else if (bit_tick) begin
      case (state)
        S_IDLE: begin
          if (!serial_in) begin
            state <= S_DATA;
            count <= '0;
          end
        end
        S_DATA: begin
          count <= count + 1'b1;
          if (count == LAST_BIT) state <= S_AFTER_DATA;
        end
`ifdef SERIAL_FRAME_PARITY_EN
        S_PARITY: state <= S_STOP;
`endif
        // The STOP tick always returns to IDLE. A start bit can only be
        // seen on a later tick, from IDLE.
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register, handshake and error flags. ena does not touch them,
  // so a pending word survives a disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_tick & ~stop_ok;

      if (capture && !drop) begin
        // The old word is either absent or being consumed right now.
        word_out   <= sipo_q;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      // A new drop takes priority over a clear issued in the same cycle.
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_ctrl
//   Directed self-checking bench for serial_frame_ctrl. A small behavioural
//   SIPO (MSB-first shift) sits on the strobes, just as the real SIPO does in
//   the wrapper. Frames are driven bit by bit, and every expected value is
//   worked out by hand from the frame being sent.
// -----------------------------------------------------------------------------
module tb_serial_frame_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int NTICKS = WIDTH + 3;
`else
  localparam int NTICKS = WIDTH + 2;
`endif

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             bit_tick;
  logic             serial_in;
  logic             sipo_clr;
  logic             sipo_shift;
  logic [WIDTH-1:0] sipo_q;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             clr_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0;

  serial_frame_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .bit_tick   (bit_tick),
    .serial_in  (serial_in),
    .sipo_clr   (sipo_clr),
    .sipo_shift (sipo_shift),
    .sipo_q     (sipo_q),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External SIPO: the first data bit ends up in the MSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sipo_q <= '0;
    else if (sipo_clr)   sipo_q <= '0;
    else if (sipo_shift) sipo_q <= {sipo_q[WIDTH-2:0], serial_in};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One serial bit: a tick in the first cycle, then period-1 idle cycles.
  task automatic send_bit(input logic b, input int period);
    serial_in = b;
    bit_tick  = 1'b1;
    next_cycle();
    bit_tick  = 1'b0;
    repeat (period - 1) next_cycle();
  endtask

  // Start bit, data MSB first, and (if enabled) a correct even-parity bit.
  task automatic send_head(input logic [WIDTH-1:0] data, input int period);
    send_bit(1'b0, period);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(data[i], period);
`ifdef SERIAL_FRAME_PARITY_EN
    send_bit(^data, period);
`endif
  endtask

  // Stop bit tick. On return, the time is just after the edge that ends STOP.
  task automatic send_stop(input logic b);
    serial_in = b;
    bit_tick  = 1'b1;
    next_cycle();
    bit_tick  = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic full_frame(input logic [WIDTH-1:0] data, input logic stop);
    send_head(data, 1);
    send_stop(stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    bit_tick   = 1'b1;
    serial_in  = 1'b0;
    word_ready = 1'b0;
    clr_err    = 1'b0;

    // Reset state. A start pattern on the line must not leak onto the strobes.
    repeat (2) next_cycle();
    check("rst_busy",   busy,       0);
    check("rst_valid",  word_valid, 0);
    check("rst_word",   word_out,   0);
    check("rst_ferr",   frame_err,  0);
    check("rst_ovr",    overrun,    0);
    check("rst_clr",    sipo_clr,   0);
    check("rst_shift",  sipo_shift, 0);
    rst_n     = 1'b1;
    bit_tick  = 1'b0;
    serial_in = 1'b1;
    next_cycle();

    // T2 nominal: line 1,0,1,0,1,1,1 gives word 4'b1011.
    serial_in = 1'b1; bit_tick = 1'b1;
    next_cycle();
    check("t2_idle_busy", busy, 0);
    serial_in = 1'b0;
    #1;
    check("t2_start_clr",   sipo_clr,   1);
    check("t2_start_shift", sipo_shift, 0);
    next_cycle();
    check("t2_data_busy", busy, 1);
    serial_in = 1'b1;
    #1;
    check("t2_data_shift", sipo_shift, 1);
    check("t2_data_clr",   sipo_clr,   0);
    next_cycle();
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
`ifdef SERIAL_FRAME_PARITY_EN
    send_bit(1'b1, 1);
`endif
    check("t2_pre_valid", word_valid, 0);
    send_stop(1'b1);
    check("t2_valid", word_valid, 1);
    check("t2_word",  word_out,   4'b1011);
    check("t2_busy",  busy,       0);
    check("t2_ferr",  frame_err,  0);
    word_ready = 1'b1;
    next_cycle();
    word_ready = 1'b0;
    check("t2_consumed", word_valid, 0);
    check("t2_word_kept", word_out, 4'b1011);

    // T3 framing error: a bad stop bit pulses frame_err for exactly one cycle.
    full_frame(4'b1011, 1'b0);
    check("t3_ferr",  frame_err,  1);
    check("t3_valid", word_valid, 0);
    check("t3_busy",  busy,       0);
    next_cycle();
    check("t3_ferr_pulse", frame_err, 0);

    // T4 overrun, with the consumer stalled.
    full_frame(4'hA, 1'b1);
    check("t4_word_a",  word_out,   4'hA);
    check("t4_valid_a", word_valid, 1);
    full_frame(4'h5, 1'b1);
    check("t4_word_kept", word_out,   4'hA);
    check("t4_overrun",   overrun,    1);
    check("t4_valid",     word_valid, 1);
    clr_err = 1'b1;
    next_cycle();
    clr_err = 1'b0;
    check("t4_ovr_clr", overrun, 0);
    // A new drop in the same cycle as clr_err keeps overrun set.
    send_head(4'h5, 1);
    clr_err = 1'b1;
    send_stop(1'b1);
    clr_err = 1'b0;
    check("t4_ovr_vs_clr", overrun, 1);
    clr_err = 1'b1;
    next_cycle();
    clr_err = 1'b0;
    check("t4_ovr_clr2", overrun, 0);

    // T5: the capture coincides with the consume, so the new word loads.
    send_head(4'h5, 1);
    word_ready = 1'b1;
    send_stop(1'b1);
    word_ready = 1'b0;
    check("t5_word",  word_out,   4'h5);
    check("t5_valid", word_valid, 1);
    check("t5_ovr",   overrun,    0);
    word_ready = 1'b1;
    next_cycle();
    word_ready = 1'b0;
    check("t5_consumed", word_valid, 0);

    // T6: a tick every 3rd cycle gives the same word at 3x latency.
    c0 = cyc;
    send_head(4'b1011, 3);
    check("t6_pre_valid", word_valid, 0);
    send_stop(1'b1);
    check("t6_latency", cyc - c0, (NTICKS - 1) * 3 + 1);
    check("t6_valid",   word_valid, 1);
    check("t6_word",    word_out,   4'b1011);
    word_ready = 1'b1;
    next_cycle();
    word_ready = 1'b0;

    // T6: ena low mid-frame returns to IDLE, and the tail of the frame
    // is not captured.
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    check("t6_ena_busy_pre", busy, 1);
    ena = 1'b0; bit_tick = 1'b1; serial_in = 1'b1;
    #1;
    check("t6_ena_shift", sipo_shift, 0);
    next_cycle();
    check("t6_ena_idle", busy, 0);
    ena = 1'b1; bit_tick = 1'b0;
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    send_stop(1'b1);
    check("t6_ena_novalid", word_valid, 0);
    check("t6_ena_noferr",  frame_err,  0);
    full_frame(4'h6, 1'b1);
    check("t6_recover", word_out, 4'h6);
    word_ready = 1'b1;
    next_cycle();
    word_ready = 1'b0;

`ifdef SERIAL_FRAME_PARITY_EN
    // The data 1011 has three ones. A parity bit of 0 leaves the count odd.
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_stop(1'b1);
    check("par_bad_ferr",  frame_err,  1);
    check("par_bad_valid", word_valid, 0);
    full_frame(4'b1011, 1'b1);
    check("par_good_word", word_out, 4'b1011);
    word_ready = 1'b1;
    next_cycle();
    word_ready = 1'b0;
`endif

    // T1: reset asserted mid-frame, with a pending word and overrun set.
    full_frame(4'h3, 1'b1);
    full_frame(4'hC, 1'b1);
    check("t1_pre_ovr", overrun, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    check("t1_pre_busy", busy, 1);
    bit_tick = 1'b1; serial_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t1_busy",  busy,       0);
    check("t1_valid", word_valid, 0);
    check("t1_word",  word_out,   0);
    check("t1_ovr",   overrun,    0);
    check("t1_ferr",  frame_err,  0);
    check("t1_clr",   sipo_clr,   0);
    check("t1_shift", sipo_shift, 0);
    next_cycle();
    rst_n = 1'b1; bit_tick = 1'b0; serial_in = 1'b1;
    next_cycle();
    full_frame(4'h9, 1'b1);
    check("t1_after_word", word_out, 4'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
